// File: rtl/hex7seg_pkg.sv
// Shared constants for the 7-segment register window: digit register layout,
// reset value and the raw active-high glyph table.
package hex7seg_pkg;

    // One digit register as seen by the CPU; bit 7 is reserved and reads 0.
    typedef logic [7:0] digit_t;

    // Digit register bit positions.
    localparam int unsigned VAL_LSB   = 0;
    localparam int unsigned VAL_MSB   = 3;
    localparam int unsigned DP_BIT    = 4;
    localparam int unsigned BLANK_BIT = 5;
    localparam int unsigned BLINK_BIT = 6;

    // Digits come out of reset blanked.
    localparam digit_t DIG_RST = 8'h20;

    // Active-high segments {g,f,e,d,c,b,a}; entry 0 is the rightmost element.
    localparam logic [15:0][6:0] FONT_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39,  // F E d C
        7'h7C, 7'h77, 7'h6F, 7'h7F,  // b A 9 8
        7'h07, 7'h7D, 7'h6D, 7'h66,  // 7 6 5 4
        7'h4F, 7'h5B, 7'h06, 7'h3F   // 3 2 1 0
    };

endpackage

// File: rtl/hex7seg_font.sv
// Combinational hex value to active-high 7-segment glyph lookup.
module hex7seg_font
    import hex7seg_pkg::*;
(
    input  logic [3:0] val,
    output logic [6:0] seg
);

    // Plain table lookup; polarity is handled by the caller.
    always_comb begin
        seg = FONT_TABLE[val];
    end

endmodule

// File: rtl/hex7seg_ctrl.sv
// CPU-side responder for the 7-segment register window. Holds four digit
// registers and drives a multiplexed common-anode display with a dead cycle
// between digits and per-digit blink.
module hex7seg_ctrl
    import hex7seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV     = 50000,
    parameter int unsigned BLINK_FRAMES = 64,
    parameter int unsigned ACTIVE_LOW   = 1
) (
    input  logic        cpu_clk,
    input  logic        rst,
    input  logic        we,
    input  logic [15:0] din,
    input  logic        cs_hex0,
    input  logic        cs_hex1,
    input  logic        cs_hex2,
    input  logic        cs_hex3,
    input  logic        read_hex0,
    input  logic        read_hex1,
    input  logic        read_hex2,
    input  logic        read_hex3,
    output logic [15:0] dout,
    output logic [7:0]  seg,
    output logic [3:0]  an
);

    localparam int unsigned PRESC_W = $clog2(SCAN_DIV);
    localparam int unsigned FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam bit          INVERT  = (ACTIVE_LOW != 0);
    localparam logic [7:0]  SEG_OFF = INVERT ? 8'hFF : 8'h00;
    localparam logic [3:0]  AN_OFF  = INVERT ? 4'hF : 4'h0;

    // Only bits 6:0 are stored; bit 7 is reserved and always reads 0.
    logic [6:0]         dig_q [4];
    logic [PRESC_W-1:0] presc_q;
    logic [1:0]         scan_idx_q;
    logic [FRAME_W-1:0] frame_q;
    logic               blink_phase_q;
    logic [7:0]         seg_q;
    logic [3:0]         an_q;

    logic [3:0] cs;
    logic       presc_wrap;
    logic       frame_last;
    logic [6:0] cur_dig;
    logic [6:0] glyph;
    logic [7:0] seg_raw;
    logic [3:0] an_raw;

    logic unused_din;
    assign unused_din = ^din[15:7];

    assign cs         = {cs_hex3, cs_hex2, cs_hex1, cs_hex0};
    assign presc_wrap = (presc_q == PRESC_W'(SCAN_DIV - 1));
    assign frame_last = (frame_q == FRAME_W'(BLINK_FRAMES - 1));
    assign cur_dig    = dig_q[scan_idx_q];

    hex7seg_font u_font (
        .val (cur_dig[VAL_MSB:VAL_LSB]),
        .seg (glyph)
    );

    // Digit registers: every selected register takes the write (illegal multi-cs included).
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                dig_q[i] <= DIG_RST[6:0];
            end
        end else if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (cs[i]) begin
                    dig_q[i] <= din[6:0];
                end
            end
        end
    end

    // Read-back mux, lowest-numbered strobe wins.
    always_comb begin
        dout = 16'h0000;
        if (read_hex0) begin
            dout = {9'h000, dig_q[0]};
        end else if (read_hex1) begin
            dout = {9'h000, dig_q[1]};
        end else if (read_hex2) begin
            dout = {9'h000, dig_q[2]};
        end else if (read_hex3) begin
            dout = {9'h000, dig_q[3]};
        end
    end

    // Prescaler, digit scan index, frame counter and blink phase.
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            presc_q       <= '0;
            scan_idx_q    <= 2'd0;
            frame_q       <= '0;
            blink_phase_q <= 1'b0;
        end else if (presc_wrap) begin
            presc_q    <= '0;
            scan_idx_q <= scan_idx_q + 2'd1;
            if (scan_idx_q == 2'd3) begin
                if (frame_last) begin
                    frame_q       <= '0;
                    blink_phase_q <= ~blink_phase_q;
                end else begin
                    frame_q <= frame_q + FRAME_W'(1);
                end
            end
        end else begin
            presc_q <= presc_q + PRESC_W'(1);
        end
    end

    // Active-high drive for the current slot; prescaler==0 is the anti-ghosting dead cycle.
    always_comb begin
        an_raw  = 4'h0;
        seg_raw = 8'h00;
        if (presc_q != '0) begin
            an_raw  = 4'b0001 << scan_idx_q;
            seg_raw = {cur_dig[DP_BIT], glyph};
            if (cur_dig[BLANK_BIT] || (cur_dig[BLINK_BIT] && blink_phase_q)) begin
                seg_raw = 8'h00;
            end
        end
    end

    // Output registers; polarity is applied only here.
    always_ff @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            seg_q <= SEG_OFF;
            an_q  <= AN_OFF;
        end else begin
            seg_q <= INVERT ? ~seg_raw : seg_raw;
            an_q  <= INVERT ? ~an_raw : an_raw;
        end
    end

    assign seg = seg_q;
    assign an  = an_q;

endmodule

// File: tb/tb_hex7seg_ctrl.sv
// Self-checking bench for hex7seg_ctrl with a small scan period so blink and
// scan behaviour are visible in a few hundred cycles.
module tb_hex7seg_ctrl;

    localparam int unsigned SCAN_DIV     = 4;
    localparam int unsigned BLINK_FRAMES = 2;
    localparam int unsigned FRAME_LEN    = SCAN_DIV * 4;
    localparam int unsigned HALF_BLINK   = FRAME_LEN * BLINK_FRAMES;

    logic        cpu_clk = 1'b0;
    logic        rst = 1'b0;
    logic        we = 1'b0;
    logic [15:0] din = 16'h0000;
    logic        cs_hex0 = 1'b0, cs_hex1 = 1'b0, cs_hex2 = 1'b0, cs_hex3 = 1'b0;
    logic        read_hex0 = 1'b0, read_hex1 = 1'b0, read_hex2 = 1'b0, read_hex3 = 1'b0;
    logic [15:0] dout;
    logic [7:0]  seg;
    logic [3:0]  an;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    hex7seg_ctrl #(
        .SCAN_DIV     (SCAN_DIV),
        .BLINK_FRAMES (BLINK_FRAMES),
        .ACTIVE_LOW   (1)
    ) dut (
        .cpu_clk   (cpu_clk),
        .rst       (rst),
        .we        (we),
        .din       (din),
        .cs_hex0   (cs_hex0),
        .cs_hex1   (cs_hex1),
        .cs_hex2   (cs_hex2),
        .cs_hex3   (cs_hex3),
        .read_hex0 (read_hex0),
        .read_hex1 (read_hex1),
        .read_hex2 (read_hex2),
        .read_hex3 (read_hex3),
        .dout      (dout),
        .seg       (seg),
        .an        (an)
    );

    always #5 cpu_clk = ~cpu_clk;

    // Reference glyphs {g..a}, active high, index = hex value.
    logic [6:0] glyph_ref [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                   7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Model state: register contents now and before the latest edge, edges since reset.
    logic [7:0] mdig [4];
    logic [7:0] mdig_prev [4];
    int         n_edges = 0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge cpu_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                mdig[i]      = 8'h20;
                mdig_prev[i] = 8'h20;
            end
            n_edges = 0;
        end else begin
            for (int i = 0; i < 4; i++) mdig_prev[i] = mdig[i];
            if (we) begin
                if (cs_hex0) mdig[0] = {1'b0, din[6:0]};
                if (cs_hex1) mdig[1] = {1'b0, din[6:0]};
                if (cs_hex2) mdig[2] = {1'b0, din[6:0]};
                if (cs_hex3) mdig[3] = {1'b0, din[6:0]};
            end
            n_edges++;
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge cpu_clk) begin
        if (chk_en) begin
            logic [3:0]  exp_an;
            logic [7:0]  exp_seg;
            logic [15:0] exp_dout;
            logic [7:0]  d;
            logic [7:0]  lit;
            int          m, slot;
            exp_an  = 4'hF;
            exp_seg = 8'hFF;
            if (!rst && n_edges > 0) begin
                m    = n_edges - 1;
                slot = (m / SCAN_DIV) % 4;
                if (m % SCAN_DIV != 0) begin
                    d   = mdig_prev[slot];
                    lit = {d[4], glyph_ref[d[3:0]]};
                    if (d[5] || (d[6] && ((m / HALF_BLINK) % 2 == 1))) lit = 8'h00;
                    exp_an  = ~(4'b0001 << slot);
                    exp_seg = ~lit;
                end
            end
            if (read_hex0)      exp_dout = {8'h00, mdig[0]};
            else if (read_hex1) exp_dout = {8'h00, mdig[1]};
            else if (read_hex2) exp_dout = {8'h00, mdig[2]};
            else if (read_hex3) exp_dout = {8'h00, mdig[3]};
            else                exp_dout = 16'h0000;
            check("cyc_an", {12'h000, an}, {12'h000, exp_an});
            check("cyc_seg", {8'h00, seg}, {8'h00, exp_seg});
            check("cyc_dout", dout, exp_dout);
        end
    end

    task automatic set_cs(input logic [3:0] v);
        {cs_hex3, cs_hex2, cs_hex1, cs_hex0} = v;
    endtask

    task automatic set_rd(input logic [3:0] v);
        {read_hex3, read_hex2, read_hex1, read_hex0} = v;
    endtask

    task automatic wr(input logic [3:0] cs_v, input logic [15:0] d, input logic w);
        @(posedge cpu_clk);
        #2;
        we  = w;
        din = d;
        set_cs(cs_v);
        @(posedge cpu_clk);
        #2;
        we = 1'b0;
        set_cs(4'h0);
    endtask

    task automatic rd(input logic [3:0] rd_v, input logic [15:0] exp, input string name);
        @(negedge cpu_clk);
        #1;
        set_rd(rd_v);
        #1;
        check(name, dout, exp);
        set_rd(4'h0);
    endtask

    task automatic wait_an(input logic [3:0] target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge cpu_clk);
            if (an == target) ok = 1'b1;
        end
    endtask

    initial begin
        bit ok;
        int cnt_on, cnt_dead, cnt_b0, cnt_ff, cnt_f;

        // Reset asserted away from an edge: outputs go to rest values immediately.
        #1 rst = 1'b1;
        #2;
        check("rst_an", {12'h000, an}, 16'h000F);
        check("rst_seg", {8'h00, seg}, 16'h00FF);
        check("rst_dout", dout, 16'h0000);
        chk_en = 1'b1;
        repeat (2) @(negedge cpu_clk);
        #2 rst = 1'b0;
        rd(4'b0100, 16'h0020, "rst_read_hex2");

        // Write / readback.
        wr(4'b0001, 16'h0005, 1'b1);
        rd(4'b0001, 16'h0005, "rd_hex0");
        wr(4'b0100, 16'hFFFF, 1'b1);
        rd(4'b0100, 16'h007F, "rd_hex2_masked");
        wr(4'b0010, 16'h1234, 1'b0);
        rd(4'b0010, 16'h0020, "rd_hex1_no_we");
        rd(4'b0011, 16'h0005, "rd_priority");

        // Scan and font.
        wr(4'b0001, 16'h0008, 1'b1);
        wr(4'b0010, 16'h0011, 1'b1);
        wr(4'b1000, 16'h0027, 1'b1);
        wait_an(4'b1110, ok);
        check("wait_dig0", {15'h0, ok}, 16'h0001);
        check("seg_dig0_8", {8'h00, seg}, 16'h0080);
        wait_an(4'b1101, ok);
        check("wait_dig1", {15'h0, ok}, 16'h0001);
        check("seg_dig1_1dp", {8'h00, seg}, 16'h0079);
        wait_an(4'b0111, ok);
        check("wait_dig3", {15'h0, ok}, 16'h0001);
        check("seg_dig3_blank", {8'h00, seg}, 16'h00FF);
        cnt_on = 0;
        cnt_dead = 0;
        repeat (16) begin
            @(negedge cpu_clk);
            if (an == 4'hF) cnt_dead++;
            else cnt_on++;
        end
        check("slots_on", 16'(cnt_on), 16'd12);
        check("slots_dead", 16'(cnt_dead), 16'd4);

        // Blink: two full blink periods contain 12 lit and 12 dark dig3 cycles.
        wr(4'b1000, 16'h0043, 1'b1);
        repeat (2) @(negedge cpu_clk);
        cnt_b0 = 0;
        cnt_ff = 0;
        repeat (2 * 2 * HALF_BLINK) begin
            @(negedge cpu_clk);
            if (an == 4'b0111 && seg == 8'hB0) cnt_b0++;
            if (an == 4'b0111 && seg == 8'hFF) cnt_ff++;
        end
        check("blink_on", 16'(cnt_b0), 16'd12);
        check("blink_off", 16'(cnt_ff), 16'd12);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            @(posedge cpu_clk);
            #2;
            we  = 1'($urandom_range(0, 1));
            din = 16'($urandom);
            if ($urandom_range(0, 7) == 0) set_cs(4'($urandom));
            else set_cs(4'b0001 << $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0) set_rd(4'h0);
            else set_rd(4'($urandom));
        end
        @(posedge cpu_clk);
        #2;
        we = 1'b0;
        set_cs(4'h0);
        set_rd(4'h0);

        // Async reset while scan_idx=2, prescaler=2.
        ok = 1'b0;
        for (int i = 0; i < 64 && !ok; i++) begin
            @(negedge cpu_clk);
            if (n_edges % FRAME_LEN == 2 * SCAN_DIV + 2) ok = 1'b1;
        end
        check("wait_midscan", {15'h0, ok}, 16'h0001);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_an", {12'h000, an}, 16'h000F);
        check("mid_rst_seg", {8'h00, seg}, 16'h00FF);
        check("mid_rst_dout", dout, 16'h0000);
        @(posedge cpu_clk);
        @(negedge cpu_clk);
        #2 rst = 1'b0;
        cnt_f = 0;
        ok = 1'b0;
        for (int i = 0; i < 16 && !ok; i++) begin
            @(negedge cpu_clk);
            if (an != 4'hF) ok = 1'b1;
            else cnt_f++;
        end
        check("restart_found", {15'h0, ok}, 16'h0001);
        check("restart_dead", 16'(cnt_f), 16'd1);
        check("restart_dig0", {12'h000, an}, 16'h000E);

        repeat (4) @(negedge cpu_clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
